// File: rtl/or1k_tlb_reload_arbiter.sv
// ----------------------------------------------------------------------------
// or1k_tlb_reload_arbiter
//   Shares one memory-side TLB reload port between the IMMU and DMMU
//   page-table walkers. A walker holds its request for the whole walk and keeps
//   the grant for that time. Between walkers the grant is round-robin. A
//   watchdog turns a bus access that never completes into an error response.
//
// Ports
//   clk, rst                       clock, synchronous active-low reset
//   immu_req_i / immu_addr_i       IMMU reload request (level) and address
//   immu_ack_o / immu_err_o        one-cycle completion / error pulse to IMMU
//   immu_data_o                    reload data, valid with immu_ack_o
//   dmmu_*                         same set for the DMMU
//   bus_req_o / bus_addr_o         request and address towards the bus adapter
//   bus_ack_i / bus_err_i          bus completion / error
//   bus_data_i                     bus read data
//   bus_abort_o                    one-cycle pulse: drop the outstanding access
//   owner_o                        current or last owner (0=IMMU, 1=DMMU)
//   busy_o                         arbiter not idle
// ----------------------------------------------------------------------------
module or1k_tlb_reload_arbiter #(
    parameter int unsigned OPTION_OPERAND_WIDTH  = 32,
    parameter int unsigned OPTION_TIMEOUT_CYCLES = 255,
    parameter int unsigned OPTION_TIMEOUT_WIDTH  = 8
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic                            immu_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] immu_addr_i,
    output logic                            immu_ack_o,
    output logic                            immu_err_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] immu_data_o,

    input  logic                            dmmu_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] dmmu_addr_i,
    output logic                            dmmu_ack_o,
    output logic                            dmmu_err_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] dmmu_data_o,

    output logic                            bus_req_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] bus_addr_o,
    input  logic                            bus_ack_i,
    input  logic                            bus_err_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] bus_data_i,
    output logic                            bus_abort_o,

    output logic                            owner_o,
    output logic                            busy_o
);

    localparam int unsigned DW = OPTION_OPERAND_WIDTH;
    localparam int unsigned TW = OPTION_TIMEOUT_WIDTH;

    localparam bit TIMEOUT_EN = (OPTION_TIMEOUT_CYCLES != 0);
    // Count value of the last ACTIVE cycle allowed before the watchdog fires.
    localparam logic [TW-1:0] TMATCH = TIMEOUT_EN ? TW'(OPTION_TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_grant_q, last_grant_d;
    logic [TW-1:0]   tcount_q, tcount_d;

    logic            immu_ack_q, immu_ack_d;
    logic            immu_err_q, immu_err_d;
    logic [DW-1:0]   immu_data_q, immu_data_d;
    logic            dmmu_ack_q, dmmu_ack_d;
    logic            dmmu_err_q, dmmu_err_d;
    logic [DW-1:0]   dmmu_data_q, dmmu_data_d;

    // Qualified events of the ACTIVE state, in priority order: completion,
    // walker withdrawal, watchdog expiry.
    logic owner_req;
    logic active;
    logic bus_done;
    logic req_lost;
    logic timeout_hit;

    assign owner_req   = owner_q ? dmmu_req_i : immu_req_i;
    assign active      = (state_q == ST_ACTIVE);
    assign bus_done    = bus_ack_i || bus_err_i;
    assign req_lost    = active && !bus_done && !owner_req;
    assign timeout_hit = TIMEOUT_EN && active && !bus_done && owner_req
                         && (tcount_q == TMATCH);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            tcount_q     <= '0;
            immu_ack_q   <= 1'b0;
            immu_err_q   <= 1'b0;
            immu_data_q  <= '0;
            dmmu_ack_q   <= 1'b0;
            dmmu_err_q   <= 1'b0;
            dmmu_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            tcount_q     <= tcount_d;
            immu_ack_q   <= immu_ack_d;
            immu_err_q   <= immu_err_d;
            immu_data_q  <= immu_data_d;
            dmmu_ack_q   <= dmmu_ack_d;
            dmmu_err_q   <= dmmu_err_d;
            dmmu_data_q  <= dmmu_data_d;
        end
    end

    // Next-state logic: grant, walk lock and watchdog counter.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        tcount_d     = tcount_q;
        unique case (state_q)
            ST_IDLE: begin
                if (immu_req_i || dmmu_req_i) begin
                    // On a tie the walker that did not own the port last time wins.
                    owner_d  = (immu_req_i && dmmu_req_i) ? !last_grant_q : dmmu_req_i;
                    tcount_d = '0;
                    state_d  = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (bus_done || req_lost || timeout_hit) begin
                    state_d = ST_GAP;
                end else if (tcount_q != '1) begin
                    tcount_d = tcount_q + TW'(1);
                end
            end
            ST_GAP: begin
                // Owner still walking: keep the port for its next access.
                if (owner_req) begin
                    tcount_d = '0;
                    state_d  = ST_ACTIVE;
                end else begin
                    last_grant_d = owner_q;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: response pulses to the owner and bus-side signals.
    always_comb begin
        immu_ack_d  = 1'b0;
        immu_err_d  = 1'b0;
        immu_data_d = immu_data_q;
        dmmu_ack_d  = 1'b0;
        dmmu_err_d  = 1'b0;
        dmmu_data_d = dmmu_data_q;

        if (active && bus_done) begin
            if (owner_q) begin
                dmmu_ack_d  = 1'b1;
                dmmu_err_d  = bus_err_i;
                dmmu_data_d = bus_data_i;
            end else begin
                immu_ack_d  = 1'b1;
                immu_err_d  = bus_err_i;
                immu_data_d = bus_data_i;
            end
        end else if (timeout_hit) begin
            // Watchdog expiry is reported as an errored completion.
            if (owner_q) begin
                dmmu_ack_d = 1'b1;
                dmmu_err_d = 1'b1;
            end else begin
                immu_ack_d = 1'b1;
                immu_err_d = 1'b1;
            end
        end

        immu_ack_o  = immu_ack_q;
        immu_err_o  = immu_err_q;
        immu_data_o = immu_data_q;
        dmmu_ack_o  = dmmu_ack_q;
        dmmu_err_o  = dmmu_err_q;
        dmmu_data_o = dmmu_data_q;

        bus_req_o   = active;
        // Address follows the owning walker combinationally.
        bus_addr_o  = owner_q ? dmmu_addr_i : immu_addr_i;
        // Abort is suppressed while reset is asserted.
        bus_abort_o = rst && (req_lost || timeout_hit);
        owner_o     = owner_q;
        busy_o      = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_or1k_tlb_reload_arbiter.sv
// ----------------------------------------------------------------------------
// tb_or1k_tlb_reload_arbiter
//   Directed bench for the TLB reload arbiter, built with a 4-cycle watchdog.
//   flags = {bus_req, busy, owner, immu_ack, immu_err, dmmu_ack, dmmu_err, abort}
// ----------------------------------------------------------------------------
module tb_or1k_tlb_reload_arbiter;

    logic        clk;
    logic        rst;
    logic        immu_req_i, dmmu_req_i;
    logic [31:0] immu_addr_i, dmmu_addr_i;
    logic        immu_ack_o, immu_err_o, dmmu_ack_o, dmmu_err_o;
    logic [31:0] immu_data_o, dmmu_data_o;
    logic        bus_req_o, bus_ack_i, bus_err_i, bus_abort_o;
    logic [31:0] bus_addr_o, bus_data_i;
    logic        owner_o, busy_o;
    logic [7:0]  flags;

    int n_checks = 0;
    int n_fail   = 0;

    or1k_tlb_reload_arbiter #(
        .OPTION_OPERAND_WIDTH  (32),
        .OPTION_TIMEOUT_CYCLES (4),
        .OPTION_TIMEOUT_WIDTH  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .immu_req_i  (immu_req_i),
        .immu_addr_i (immu_addr_i),
        .immu_ack_o  (immu_ack_o),
        .immu_err_o  (immu_err_o),
        .immu_data_o (immu_data_o),
        .dmmu_req_i  (dmmu_req_i),
        .dmmu_addr_i (dmmu_addr_i),
        .dmmu_ack_o  (dmmu_ack_o),
        .dmmu_err_o  (dmmu_err_o),
        .dmmu_data_o (dmmu_data_o),
        .bus_req_o   (bus_req_o),
        .bus_addr_o  (bus_addr_o),
        .bus_ack_i   (bus_ack_i),
        .bus_err_i   (bus_err_i),
        .bus_data_i  (bus_data_i),
        .bus_abort_o (bus_abort_o),
        .owner_o     (owner_o),
        .busy_o      (busy_o)
    );

    assign flags = {bus_req_o, busy_o, owner_o, immu_ack_o, immu_err_o,
                    dmmu_ack_o, dmmu_err_o, bus_abort_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        immu_req_i = 1'b0; dmmu_req_i = 1'b0;
        bus_ack_i  = 1'b0; bus_err_i  = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        immu_req_i = 1'b0; dmmu_req_i = 1'b0;
        immu_addr_i = '0; dmmu_addr_i = '0;
        bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_data_i = '0;
        tick();
        tick();
        #1;
        n_checks++; if (flags !== 8'h00) begin n_fail++; $display("FAIL reset_flags: got %b want %b", flags, 8'h00); end
        n_checks++; if (immu_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_immu_data: got %h want %h", immu_data_o, 32'h0); end
        n_checks++; if (dmmu_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_dmmu_data: got %h want %h", dmmu_data_o, 32'h0); end
        rst = 1'b1;
    endtask

    task automatic test_immu_walk();
        immu_req_i = 1'b1; immu_addr_i = 32'h0000_1000;
        #1;
        n_checks++; if (flags !== 8'b0000_0000) begin n_fail++; $display("FAIL walk_idle: got %b want %b", flags, 8'b0000_0000); end
        tick(); // ACTIVE, 1st cycle
        n_checks++; if (flags !== 8'b1100_0000) begin n_fail++; $display("FAIL walk_active1: got %b want %b", flags, 8'b1100_0000); end
        n_checks++; if (bus_addr_o !== 32'h0000_1000) begin n_fail++; $display("FAIL walk_addr1: got %h want %h", bus_addr_o, 32'h0000_1000); end
        tick();
        tick(); // 3rd ACTIVE cycle: bus acks
        bus_ack_i = 1'b1; bus_data_i = 32'h8000_2400;
        #1;
        n_checks++; if (flags !== 8'b1100_0000) begin n_fail++; $display("FAIL walk_ack_cycle: got %b want %b", flags, 8'b1100_0000); end
        tick(); // GAP
        bus_ack_i = 1'b0; immu_addr_i = 32'h8000_2008;
        #1;
        n_checks++; if (flags !== 8'b0101_0000) begin n_fail++; $display("FAIL walk_gap1: got %b want %b", flags, 8'b0101_0000); end
        n_checks++; if (immu_data_o !== 32'h8000_2400) begin n_fail++; $display("FAIL walk_data1: got %h want %h", immu_data_o, 32'h8000_2400); end
        tick(); // ACTIVE again with new address
        n_checks++; if (flags !== 8'b1100_0000) begin n_fail++; $display("FAIL walk_active2: got %b want %b", flags, 8'b1100_0000); end
        n_checks++; if (bus_addr_o !== 32'h8000_2008) begin n_fail++; $display("FAIL walk_addr2: got %h want %h", bus_addr_o, 32'h8000_2008); end
        bus_ack_i = 1'b1; bus_data_i = 32'h1111_0000;
        tick(); // GAP
        bus_ack_i = 1'b0; immu_req_i = 1'b0;
        #1;
        n_checks++; if (flags !== 8'b0101_0000) begin n_fail++; $display("FAIL walk_gap2: got %b want %b", flags, 8'b0101_0000); end
        n_checks++; if (immu_data_o !== 32'h1111_0000) begin n_fail++; $display("FAIL walk_data2: got %h want %h", immu_data_o, 32'h1111_0000); end
        tick(); // IDLE
        n_checks++; if (flags !== 8'b0000_0000) begin n_fail++; $display("FAIL walk_release: got %b want %b", flags, 8'b0000_0000); end
        // IMMU was the last owner, so a tie now goes to DMMU.
        immu_req_i = 1'b1; dmmu_req_i = 1'b1;
        tick();
        n_checks++; if (flags !== 8'b1110_0000) begin n_fail++; $display("FAIL walk_last_grant: got %b want %b", flags, 8'b1110_0000); end
        do_reset();
    endtask

    task automatic test_round_robin();
        logic own;
        immu_addr_i = 32'hA000_0000; dmmu_addr_i = 32'hB000_0000;
        immu_req_i = 1'b1; dmmu_req_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            own = (k % 2) == 1;
            #1;
            n_checks++; if ({bus_req_o, busy_o} !== 2'b00) begin n_fail++; $display("FAIL rr_idle%0d: got %b want %b", k, {bus_req_o, busy_o}, 2'b00); end
            tick(); // ACTIVE
            n_checks++; if (flags !== {2'b11, own, 5'b0}) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", k, flags, {2'b11, own, 5'b0}); end
            n_checks++; if (bus_addr_o !== (own ? 32'hB000_0000 : 32'hA000_0000)) begin n_fail++; $display("FAIL rr_addr%0d: got %h want %h", k, bus_addr_o, (own ? 32'hB000_0000 : 32'hA000_0000)); end
            bus_ack_i = 1'b1; bus_data_i = 32'hC000_0000 + 32'(k);
            tick(); // GAP
            bus_ack_i = 1'b0;
            #1;
            n_checks++; if (flags !== {1'b0, 1'b1, own, !own, 1'b0, own, 2'b00}) begin n_fail++; $display("FAIL rr_gap%0d: got %b want %b", k, flags, {1'b0, 1'b1, own, !own, 1'b0, own, 2'b00}); end
            n_checks++; if ((own ? dmmu_data_o : immu_data_o) !== 32'hC000_0000 + 32'(k)) begin n_fail++; $display("FAIL rr_data%0d: got %h want %h", k, (own ? dmmu_data_o : immu_data_o), 32'hC000_0000 + 32'(k)); end
            if (own) dmmu_req_i = 1'b0; else immu_req_i = 1'b0;
            tick(); // IDLE, owner re-requests together with the other walker
            immu_req_i = 1'b1; dmmu_req_i = 1'b1;
        end
        do_reset();
    endtask

    task automatic test_lock();
        dmmu_addr_i = 32'hD000_0010; immu_addr_i = 32'h0000_3000;
        dmmu_req_i = 1'b1;
        tick(); // DMMU ACTIVE
        n_checks++; if (flags !== 8'b1110_0000) begin n_fail++; $display("FAIL lock_grant: got %b want %b", flags, 8'b1110_0000); end
        bus_ack_i = 1'b1; bus_data_i = 32'h0000_0005;
        tick(); // GAP: IMMU raises its request here
        bus_ack_i = 1'b0; immu_req_i = 1'b1; dmmu_addr_i = 32'hD000_0020;
        #1;
        n_checks++; if (flags !== 8'b0110_0100) begin n_fail++; $display("FAIL lock_gap1: got %b want %b", flags, 8'b0110_0100); end
        tick(); // still DMMU
        n_checks++; if (flags !== 8'b1110_0000) begin n_fail++; $display("FAIL lock_held: got %b want %b", flags, 8'b1110_0000); end
        n_checks++; if (bus_addr_o !== 32'hD000_0020) begin n_fail++; $display("FAIL lock_addr: got %h want %h", bus_addr_o, 32'hD000_0020); end
        bus_ack_i = 1'b1;
        tick(); // GAP, DMMU finishes
        bus_ack_i = 1'b0; dmmu_req_i = 1'b0;
        #1;
        n_checks++; if (flags !== 8'b0110_0100) begin n_fail++; $display("FAIL lock_gap2: got %b want %b", flags, 8'b0110_0100); end
        tick(); // IDLE
        n_checks++; if (flags !== 8'b0010_0000) begin n_fail++; $display("FAIL lock_idle: got %b want %b", flags, 8'b0010_0000); end
        tick(); // IMMU ACTIVE
        n_checks++; if (flags !== 8'b1100_0000) begin n_fail++; $display("FAIL lock_immu_grant: got %b want %b", flags, 8'b1100_0000); end
        n_checks++; if (bus_addr_o !== 32'h0000_3000) begin n_fail++; $display("FAIL lock_immu_addr: got %h want %h", bus_addr_o, 32'h0000_3000); end
        // IMMU walker withdraws mid-access.
        immu_req_i = 1'b0;
        #1;
        n_checks++; if (flags !== 8'b1100_0001) begin n_fail++; $display("FAIL drop_abort: got %b want %b", flags, 8'b1100_0001); end
        tick(); // GAP without response
        n_checks++; if (flags !== 8'b0100_0000) begin n_fail++; $display("FAIL drop_gap: got %b want %b", flags, 8'b0100_0000); end
        tick();
        n_checks++; if (flags !== 8'b0000_0000) begin n_fail++; $display("FAIL drop_idle: got %b want %b", flags, 8'b0000_0000); end
        do_reset();
    endtask

    task automatic test_timeout();
        immu_addr_i = 32'h0000_4000; bus_data_i = 32'hFFFF_FFFF;
        immu_req_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_checks++; if (flags !== {7'b1100_000, (i == 4)}) begin n_fail++; $display("FAIL timeout_cycle%0d: got %b want %b", i, flags, {7'b1100_000, (i == 4)}); end
        end
        tick(); // GAP with errored response
        immu_req_i = 1'b0;
        #1;
        n_checks++; if (flags !== 8'b0101_1000) begin n_fail++; $display("FAIL timeout_gap: got %b want %b", flags, 8'b0101_1000); end
        n_checks++; if (immu_data_o !== 32'h0) begin n_fail++; $display("FAIL timeout_data: got %h want %h", immu_data_o, 32'h0); end
        tick();
        n_checks++; if (flags !== 8'b0000_0000) begin n_fail++; $display("FAIL timeout_idle: got %b want %b", flags, 8'b0000_0000); end
        do_reset();
    endtask

    task automatic test_bus_error();
        dmmu_addr_i = 32'hE000_0000;
        dmmu_req_i = 1'b1;
        tick(); // ACTIVE
        bus_ack_i = 1'b1; bus_err_i = 1'b1; bus_data_i = 32'hDEAD_0001;
        #1;
        n_checks++; if (flags !== 8'b1110_0000) begin n_fail++; $display("FAIL berr_active: got %b want %b", flags, 8'b1110_0000); end
        tick(); // GAP
        bus_ack_i = 1'b0; bus_err_i = 1'b0;
        #1;
        n_checks++; if (flags !== 8'b0110_0110) begin n_fail++; $display("FAIL berr_gap: got %b want %b", flags, 8'b0110_0110); end
        n_checks++; if (dmmu_data_o !== 32'hDEAD_0001) begin n_fail++; $display("FAIL berr_data: got %h want %h", dmmu_data_o, 32'hDEAD_0001); end
        n_checks++; if (immu_data_o !== 32'h0) begin n_fail++; $display("FAIL berr_other_data: got %h want %h", immu_data_o, 32'h0); end
        tick(); // ACTIVE again; ack arrives on the watchdog's last cycle
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) tick();
            if (i == 4) begin bus_ack_i = 1'b1; bus_data_i = 32'h1234_5678; end
            #1;
            n_checks++; if (flags !== 8'b1110_0000) begin n_fail++; $display("FAIL ack_vs_timeout%0d: got %b want %b", i, flags, 8'b1110_0000); end
        end
        tick(); // GAP, ack without error
        bus_ack_i = 1'b0; dmmu_req_i = 1'b0;
        #1;
        n_checks++; if (flags !== 8'b0110_0100) begin n_fail++; $display("FAIL ack_vs_timeout_gap: got %b want %b", flags, 8'b0110_0100); end
        n_checks++; if (dmmu_data_o !== 32'h1234_5678) begin n_fail++; $display("FAIL ack_vs_timeout_data: got %h want %h", dmmu_data_o, 32'h1234_5678); end
        tick();
        n_checks++; if (flags !== 8'b0010_0000) begin n_fail++; $display("FAIL berr_idle: got %b want %b", flags, 8'b0010_0000); end
        do_reset();
    endtask

    task automatic test_reset_mid_active();
        immu_addr_i = 32'h0000_5000; dmmu_addr_i = 32'hF000_0000;
        immu_req_i = 1'b1;
        tick(); // IMMU ACTIVE
        bus_ack_i = 1'b1; bus_data_i = 32'h0000_7777;
        tick(); // GAP
        bus_ack_i = 1'b0; immu_req_i = 1'b0;
        tick(); // IDLE, IMMU was last owner
        dmmu_req_i = 1'b1;
        tick(); // DMMU ACTIVE cycle 1
        tick();
        tick();
        tick(); // cycle 4 would time out; reset instead
        rst = 1'b0;
        #1;
        n_checks++; if (flags !== 8'b1110_0000) begin n_fail++; $display("FAIL rstmid_no_abort: got %b want %b", flags, 8'b1110_0000); end
        tick();
        n_checks++; if (flags !== 8'b0000_0000) begin n_fail++; $display("FAIL rstmid_flags: got %b want %b", flags, 8'b0000_0000); end
        n_checks++; if (immu_data_o !== 32'h0) begin n_fail++; $display("FAIL rstmid_data: got %h want %h", immu_data_o, 32'h0); end
        rst = 1'b1; immu_req_i = 1'b1; dmmu_req_i = 1'b1;
        tick();
        n_checks++; if (flags !== 8'b1100_0000) begin n_fail++; $display("FAIL rstmid_tie: got %b want %b", flags, 8'b1100_0000); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_immu_walk();
        test_round_robin();
        test_lock();
        test_timeout();
        test_bus_error();
        test_reset_mid_active();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
